// File: rtl/seg_capture_pkg.sv
// Shared constants for reading back active-low 7-segment patterns.
// Pattern bit 6 is segment a, bit 0 is segment g; a 0 bit means the segment is lit.
package seg_capture_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [4:0] CODE_DASH    = 5'h10;
   localparam logic [4:0] CODE_BLANK   = 5'h1E;
   localparam logic [4:0] CODE_INVALID = 5'h1F;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETTLE   = 2'd1,
      CAPTURED = 2'd2
   } cap_state_e;

endpackage

// File: rtl/seg_pattern_to_code.sv
// Combinational lookup from an active-low segment pattern to its 5-bit digit code.
// Blank is a legal code; anything outside the table flags invalid.
module seg_pattern_to_code
   import seg_capture_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [4:0] code,
   output logic       invalid
);

   always_comb begin
      code    = CODE_INVALID;
      invalid = 1'b0;
      case (pattern)
         SEG_0:     code = 5'h00;
         SEG_1:     code = 5'h01;
         SEG_2:     code = 5'h02;
         SEG_3:     code = 5'h03;
         SEG_4:     code = 5'h04;
         SEG_5:     code = 5'h05;
         SEG_6:     code = 5'h06;
         SEG_7:     code = 5'h07;
         SEG_8:     code = 5'h08;
         SEG_9:     code = 5'h09;
         SEG_A:     code = 5'h0A;
         SEG_B:     code = 5'h0B;
         SEG_C:     code = 5'h0C;
         SEG_D:     code = 5'h0D;
         SEG_E:     code = 5'h0E;
         SEG_F:     code = 5'h0F;
         SEG_DASH:  code = CODE_DASH;
         SEG_BLANK: code = CODE_BLANK;
         default: begin
            code    = CODE_INVALID;
            invalid = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/seg_capture_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and recovers the per-digit codes,
// capturing a digit only after its {anode, segment} word has been stable long enough.
module seg_capture_decoder
   import seg_capture_pkg::*;
#(
   parameter int NUM_DIGITS    = 6,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [0:6]              seg_in,
   input  logic [NUM_DIGITS-1:0]   anode_n,
   input  logic                    clear_err,
   output logic [5*NUM_DIGITS-1:0] digit_codes,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    frame_done,
   output logic                    pattern_err
);

   localparam int         SW       = NUM_DIGITS + 7;
   localparam int         IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 2);

   logic [6:0]            seg_s1, seg_s2;
   logic [NUM_DIGITS-1:0] an_s1, an_s2;
   logic [SW-1:0]         samp, prev_samp;
   logic                  same, sel_valid;
   logic [IW-1:0]         sel_idx;
   logic [4:0]            dec_code;
   logic                  dec_invalid;

   cap_state_e            state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  capture;
   logic [NUM_DIGITS-1:0] mask_q, cap_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1    <= '1;
         seg_s2    <= '1;
         an_s1     <= '1;
         an_s2     <= '1;
         prev_samp <= '1;
      end else begin
         seg_s1    <= seg_in;
         seg_s2    <= seg_s1;
         an_s1     <= anode_n;
         an_s2     <= an_s1;
         prev_samp <= samp;
      end
   end

   assign samp      = {an_s2, seg_s2};
   assign same      = (samp == prev_samp);
   assign sel_valid = $onehot(~an_s2);

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!an_s2[i]) sel_idx = IW'(i);
      end
   end

   seg_pattern_to_code u_dec (
      .pattern (seg_s2),
      .code    (dec_code),
      .invalid (dec_invalid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The capture fires on the edge where the counter would reach STABLE_CYCLES-1,
   // i.e. after STABLE_CYCLES identical synchronized samples.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (sel_valid) state_d = SETTLE;
         end
         SETTLE: begin
            if (!sel_valid) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (!same) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               capture = 1'b1;
               state_d = CAPTURED;
               cnt_d   = cnt_q + 8'd1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         CAPTURED: begin
            if (!same) begin
               cnt_d   = '0;
               state_d = sel_valid ? SETTLE : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign cap_bit = capture ? (NUM_DIGITS'(1) << sel_idx) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_codes <= {NUM_DIGITS{CODE_BLANK}};
         digit_valid <= '0;
         frame_done  <= 1'b0;
         pattern_err <= 1'b0;
         mask_q      <= '0;
      end else begin
         if (capture) begin
            digit_codes[5*sel_idx +: 5] <= dec_code;
            digit_valid[sel_idx]        <= 1'b1;
         end
         // A full mask is reported and cleared together; a capture on that edge starts the next frame.
         frame_done <= (mask_q == '1);
         mask_q     <= ((mask_q == '1) ? '0 : mask_q) | cap_bit;
         if (capture && dec_invalid) pattern_err <= 1'b1;
         else if (clear_err)         pattern_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Scoreboard bench for seg_capture_decoder: a run-length reference model predicts every
// cycle's outputs into a queue and a monitor compares them against the DUT.
module tb_seg_capture_decoder;

   localparam int N      = 6;
   localparam int STABLE = 4;
   localparam int SW     = N + 7;
   localparam int OW     = 5*N + N + 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [0:6]     seg_in = 7'b1111111;
   logic [N-1:0]   anode_n = '1;
   logic           clear_err = 1'b0;
   logic [5*N-1:0] digit_codes;
   logic [N-1:0]   digit_valid;
   logic           frame_done;
   logic           pattern_err;

   int errors = 0;
   int checks = 0;
   logic [OW-1:0] exp_q[$];

   seg_capture_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(STABLE)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .anode_n     (anode_n),
      .clear_err   (clear_err),
      .digit_codes (digit_codes),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .pattern_err (pattern_err)
   );

   initial forever #5 clk = ~clk;

   // Pattern table: a..g left to right, 0 = lit.
   logic [6:0] ref_pat [17];
   logic [4:0] ref_code[17];
   initial begin
      ref_pat[0]  = 7'b0000001; ref_pat[1]  = 7'b1001111; ref_pat[2]  = 7'b0010010;
      ref_pat[3]  = 7'b0000110; ref_pat[4]  = 7'b1001100; ref_pat[5]  = 7'b0100100;
      ref_pat[6]  = 7'b0100000; ref_pat[7]  = 7'b0001111; ref_pat[8]  = 7'b0000000;
      ref_pat[9]  = 7'b0000100; ref_pat[10] = 7'b0001000; ref_pat[11] = 7'b1100000;
      ref_pat[12] = 7'b0110001; ref_pat[13] = 7'b1000010; ref_pat[14] = 7'b0110000;
      ref_pat[15] = 7'b0111000; ref_pat[16] = 7'b1111110;
      for (int i = 0; i < 16; i++) ref_code[i] = 5'(i);
      ref_code[16] = 5'h10;
   end

   function automatic void ref_decode(input logic [6:0] p, output logic [4:0] c, output logic inv);
      c   = 5'h1F;
      inv = 1'b1;
      if (p == 7'b1111111) begin
         c   = 5'h1E;
         inv = 1'b0;
      end
      for (int i = 0; i < 17; i++) begin
         if (ref_pat[i] == p) begin
            c   = ref_code[i];
            inv = 1'b0;
         end
      end
   endfunction

   // Reference model: two-stage pin delay, then a capture when a valid sample word has
   // been seen on exactly STABLE consecutive cycles.
   logic [SW-1:0] m_p1, m_p2, m_last;
   int            m_run;
   logic [4:0]    m_codes[N];
   logic [N-1:0]  m_valid, m_mask;
   logic          m_fd, m_err;

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_p1 = '1; m_p2 = '1; m_last = '1; m_run = 0;
            for (int i = 0; i < N; i++) m_codes[i] = 5'h1E;
            m_valid = '0; m_mask = '0; m_fd = 1'b0; m_err = 1'b0;
         end else begin
            logic [SW-1:0] s;
            logic [N-1:0]  an, nmask;
            logic          cap, inv, full;
            logic [4:0]    c;
            int            idx;
            s = m_p2;
            if (s == m_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
            else             m_run = 1;
            m_last = s;
            an  = s[SW-1:7];
            cap = ($countones(~an) == 1) && (m_run == STABLE);
            full  = (m_mask == '1);
            nmask = full ? '0 : m_mask;
            idx = 0;
            for (int i = 0; i < N; i++) if (!an[i]) idx = i;
            ref_decode(s[6:0], c, inv);
            if (cap) begin
               m_codes[idx] = c;
               m_valid[idx] = 1'b1;
               nmask[idx]   = 1'b1;
            end
            if (cap && inv)     m_err = 1'b1;
            else if (clear_err) m_err = 1'b0;
            m_fd   = full;
            m_mask = nmask;
            m_p2   = m_p1;
            m_p1   = {anode_n, seg_in};
         end
         begin
            logic [5*N-1:0] pc;
            for (int i = 0; i < N; i++) pc[5*i +: 5] = m_codes[i];
            exp_q.push_back({pc, m_valid, m_fd, m_err});
         end
      end
   end

   // Monitor: compares each cycle's registered outputs with the model's prediction.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t", $time);
         end else begin
            logic [OW-1:0] e, a;
            e = exp_q.pop_front();
            a = {digit_codes, digit_valid, frame_done, pattern_err};
            if (a !== e) begin
               errors++;
               $display("FAIL outputs t=%0t got codes=%h valid=%b fd=%b err=%b exp codes=%h valid=%b fd=%b err=%b",
                        $time, a[OW-1 -: 5*N], a[N+1:2], a[1], a[0], e[OW-1 -: 5*N], e[N+1:2], e[1], e[0]);
            end
         end
      end
   end

   task automatic drive(input logic [N-1:0] an, input logic [6:0] seg, input int n);
      anode_n = an;
      seg_in  = seg;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_now(input string name, input logic [OW-1:0] exp_v);
      logic [OW-1:0] a;
      a = {digit_codes, digit_valid, frame_done, pattern_err};
      checks++;
      if (a !== exp_v) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, a, exp_v);
      end
   endtask

   logic [OW-1:0] reset_vec;
   logic [6:0]    seg_v;
   logic [N-1:0]  an_v;

   initial begin
      reset_vec = {{N{5'h1E}}, {N{1'b0}}, 1'b0, 1'b0};
      repeat (3) @(negedge clk);
      check_now("reset_state", reset_vec);
      rst_n = 1'b1;

      // Idle bus, then a single held digit 0 = '2'.
      drive('1, 7'b1111111, 10);
      drive(6'b111110, 7'b0010010, 10);

      // Scan a full frame: 1, 2, 3, A, dash, blank.
      drive(6'b111110, 7'b1001111, 8);
      drive(6'b111101, 7'b0010010, 8);
      drive(6'b111011, 7'b0000110, 8);
      drive(6'b110111, 7'b0001000, 8);
      drive(6'b101111, 7'b1111110, 8);
      drive(6'b011111, 7'b1111111, 8);
      drive('1, 7'b1111111, 4);

      // Invalid pattern, clear, then clear coinciding with a new invalid capture.
      drive(6'b110111, 7'b1010101, 8);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      drive(6'b110111, 7'b0101010, 5);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (pattern_err !== 1'b1) begin
         errors++;
         $display("FAIL err_set_wins got=%b exp=1", pattern_err);
      end

      // Glitching pattern, then two anodes selected.
      for (int k = 0; k < 6; k++) drive(6'b111101, (k % 2) ? 7'b0000000 : 7'b0001111, 2);
      drive(6'b111100, 7'b0100100, 10);
      drive('1, 7'b1111111, 4);

      // Reset while the counter sits at 2, then recapture the same held input.
      drive(6'b111011, 7'b0110000, 5);
      rst_n = 1'b0;
      #1;
      check_now("reset_mid_settle", reset_vec);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive(6'b111011, 7'b0110000, 10);

      // Randomized traffic.
      for (int t = 0; t < 300; t++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 8)       an_v = ~(N'(1) << $urandom_range(0, N-1));
         else if (r == 8) an_v = '1;
         else             an_v = N'($urandom);
         if ($urandom_range(0, 9) < 7) seg_v = ($urandom_range(0, 17) == 17) ? 7'b1111111
                                                : ref_pat[$urandom_range(0, 16)];
         else                          seg_v = 7'($urandom);
         anode_n = an_v;
         seg_in  = seg_v;
         for (int c = 0; c < $urandom_range(1, 9); c++) begin
            clear_err = ($urandom_range(0, 15) == 0);
            @(negedge clk);
         end
         clear_err = 1'b0;
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_capture_decoder.md
Name: seg_capture_decoder

Overview:
Reader-side counterpart of the team's 7-segment display drivers. It samples an external multiplexed, active-low 7-segment bus (segments a..g plus per-digit anode selects) and recovers the 5-bit digit codes that produced each pattern. Codes are 0x0–0xF hex, 0x10 dash, plus blank and invalid markers. It sits in loopback/self-test and display-snoop paths, so benches and on-chip checkers can read back what a display driver is actually showing.

Parameters:
NUM_DIGITS, 6, number of multiplexed digits / anode lines (1..8)
STABLE_CYCLES, 4, consecutive identical synchronized samples required before a capture (2..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
seg_in  in  [0:6]  active-low segments, index 0 = a … index 6 = g (same ordering as display drivers)
anode_n  in  NUM_DIGITS  active-low one-hot digit select
clear_err  in  1  synchronous pulse, clears pattern_err
digit_codes  out  5*NUM_DIGITS  code of digit i at bits [5i+4:5i]
digit_valid  out  NUM_DIGITS  bit i set once digit i has been captured since reset
frame_done  out  1  one-cycle pulse when every digit has been captured since the previous pulse
pattern_err  out  1  sticky, set on capture of an unrecognized pattern

Behaviour:
- Reset (async assert, sync-released use): digit_codes all 5'h1E, digit_valid 0, frame_done 0, pattern_err 0, FSM IDLE, stability counter 0, frame mask 0, sync flops all-ones.
- Input sync: seg_in and anode_n each pass through 2 flops; all logic uses the synchronized values.
- Sample word S = {anode_n_sync, seg_sync}. Valid select = exactly one anode_n_sync bit low.
- FSM:
  - IDLE: no valid select. Counter 0. On a valid select -> SETTLE, counter 0.
  - SETTLE: if S equals the previous cycle's S, counter++. Otherwise counter 0 (stay, or go to IDLE if the select is no longer valid). When counter reaches STABLE_CYCLES-1 with S unchanged, capture -> CAPTURED.
  - CAPTURED: hold. Any change in S -> SETTLE (or IDLE if the select is invalid) with counter 0. There is no re-capture while S is unchanged.
- Capture (single cycle): for selected digit i, write the decoded code into digit_codes[i]. Set digit_valid[i] and frame-mask bit i.
- Capture latency: an input change that is held steady is captured on the cycle 2 + STABLE_CYCLES clocks after it reaches the pins. Outputs update the following edge (registered).
- Pattern decode, seg a..g, 0 = lit:
  - Digits: 0000001 -> 0, 1001111 -> 1, 0010010 -> 2, 0000110 -> 3, 1001100 -> 4, 0100100 -> 5, 0100000 -> 6, 0001111 -> 7, 0000000 -> 8, 0000100 -> 9.
  - Hex letters and dash: 0001000 -> A, 1100000 -> B, 0110001 -> C, 1000010 -> D, 0110000 -> E, 0111000 -> F, 1111110 -> 0x10.
  - 1111111 -> 0x1E (blank, not an error).
  - Anything else -> 0x1F and sets pattern_err.
- frame_done: when the frame mask becomes all-ones, pulse for 1 cycle and clear the mask on the same edge. A capture on that same edge sets its bit in the new mask. Repeat captures of the same digit within a frame overwrite the code and do not double count.
- Simultaneous error set and clear_err: set wins.
- Multiple anodes low, or none: no capture. Stay in or return to IDLE. The counter is cleared.
- Reset mid-SETTLE: all state is discarded immediately. After release, the full 2 + STABLE_CYCLES latency applies again.

Decomposition:
- Package seg_capture_pkg: SEG_* 7-bit pattern constants for 0–F and dash; CODE_DASH = 5'h10, CODE_BLANK = 5'h1E, CODE_INVALID = 5'h1F; FSM state enum (IDLE, SETTLE, CAPTURED).
- Sub-module seg_pattern_to_code: purely combinational pattern-to-code lookup with an invalid flag, reusable by other checkers.
- Top: synchronizers, FSM, counter, capture registers, frame mask.

Test Plan:
1. Reset, then idle inputs (all ones) -> digit_codes all 0x1E, digit_valid 0, frame_done never pulses.
2. anode_n = 6'b111110, seg_in = 0010010 held 10 cycles -> digit_codes[4:0] = 0x02 and digit_valid[0] = 1 exactly 6 cycles after the pin change; exactly one capture.
3. Scan digits 0..5 with patterns 1, 2, 3, A, dash, blank (8 cycles each) -> codes 0x01, 0x02, 0x03, 0x0A, 0x10, 0x1E; frame_done pulses once, after digit 5's capture; pattern_err stays 0.
4. Digit 3 with seg_in = 1010101 -> digit_codes for digit 3 = 0x1F, pattern_err = 1. Pulse clear_err -> 0. clear_err on the same cycle as a new invalid capture -> stays 1.
5. Glitch: pattern toggles every 2 cycles, and anode_n = 6'b111100 (two digits selected) -> no capture, digit_valid unchanged.
6. Assert rst_n low on counter = 2 during a SETTLE -> outputs return to reset values immediately; the same held input is recaptured 6 cycles after release.
